seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Parametrised multiplexed seven-segment display driver. It captures an unsigned binary value and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It then scans the result across DIGITS common-anode digits, with optional leading-zero blanking, per-digit decimal points and overflow indication. It sits between the datapath and the board anode/cathode pins in the top module, replacing per-digit combinational decode.

## Interface
- DIGITS, 4: number of display digits (1..8).
- WIDTH, 14: binary input width (1..27).
- REFRESH_DIV, 100000: clock cycles each digit is held active (>=2).
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- value  in  WIDTH  unsigned binary value to display.
- load  in  1  capture request, sampled each edge.
- dp_mask  in  DIGITS  bit i set -> decimal point lit on digit i (digit 0 = rightmost); sampled live, not captured.
- blank_lz  in  1  1 -> suppress leading zeros; sampled live.
- busy  out  1  conversion in progress.
- overflow  out  1  last captured value >= 10^DIGITS.
- an  out  DIGITS  anode enables, active-low, one-hot-low while scanning.
- seg  out  8  cathodes, active-low: bit7=a, 6=b, 5=c, 4=d, 3=e, 2=f, 1=g, 0=dp.

## Operation
- Glyphs (seg[7:1], dp bit added separately):
  - 0=000000_1, 1=100111_1, 2=001001_0, 3=000011_0, 4=100110_0.
  - 5=010010_0, 6=010000_0, 7=000111_1, 8=000000_0, 9=000010_0.
  - Dash = g only (1111110). Blank = 1111111.
- Conversion FSM, states IDLE -> SHIFT -> COMMIT -> IDLE.
  - IDLE: load=1 captures value into the shift register, clears the BCD field, evaluates overflow (value >= 10^DIGITS), loads counter = WIDTH, goes to SHIFT.
  - SHIFT: per cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left 1; decrement counter; go to COMMIT after WIDTH shifts.
  - COMMIT: copy BCD (4*DIGITS bits) and the overflow flag into the display registers in one edge; go to IDLE.
- load while busy is ignored (not queued); displayed data is never partially updated.
- Scan: divider counts 0..REFRESH_DIV-1; at terminal count it wraps to 0 and the digit index advances, DIGITS-1 wraps to 0.
- Output mux, registered every cycle from index i:
  - an = all ones except bit i = 0.
  - seg[7:1] = dash if display overflow is set.
  - Else blank if blank_lz=1, i>0, and digits i..DIGITS-1 are all zero.
  - Else the glyph of BCD digit i.
  - seg[0] = ~dp_mask[i]. A lit dp is shown even on blanked and dash digits.
- Digit 0 is never blanked; value 0 shows a single "0".

## Timing
- Reset values:
  - an = all ones, seg = 8'hFF, busy = 0, overflow = 0.
  - Display BCD = 0, digit index = 0, divider = 0, FSM = IDLE.
- First edge after reset release: an[0]=0, seg=8'b0000_0011 (blank_lz irrelevant for digit 0; dp_mask=0).
- load sampled at edge E0 -> busy=1 after E0, SHIFT on E1..E(WIDTH), COMMIT at E(WIDTH+1).
  - busy=0 and overflow updated after E(WIDTH+1); busy high exactly WIDTH+1 cycles.
  - New glyph on seg one edge after COMMIT, for the currently scanned digit.
- A new load is accepted at the first edge where busy=0 (back-to-back every WIDTH+2 cycles).
- Scan advance: index changes on the edge where the divider wraps; an/seg reflect it one edge later. Each digit is active REFRESH_DIV cycles.
- Scan and conversion are independent; COMMIT mid-digit changes seg without disturbing the divider.
- rst mid-conversion: immediate return to reset values; the partial conversion is discarded; a pending load is lost.

## Test plan
- Reset then release, dp_mask=0 -> an=4'b1110, seg=8'h03 one edge later; scan an 1110->1101->1011->0111->1110 every REFRESH_DIV (use 4) cycles.
- load value=1234 -> busy high 15 cycles; digits 3..0 show glyphs 1,2,3,4; overflow=0.
- value=7, blank_lz=1 -> digits 3..1 seg=8'hFF, digit 0 = glyph 7 (8'h1F); blank_lz=0 -> digits 3..1 = 8'h03.
- value=12000 (>=10^4) -> overflow=1, all digits seg=8'hFD; dp_mask=4'b0100 -> digit 2 seg=8'hFC.
- load value=9999 then load=1 again on cycles 2..10 with value=5 -> second load ignored, display 9999; load after busy falls -> display 5 after 15 cycles.
- Assert rst on cycle 7 of a conversion -> outputs at reset values immediately; after release, display shows 0, busy=0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment driver: captures a binary value, converts it to BCD
// with a sequential double-dabble engine and scans the digits onto common-anode pins.
module seg_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 14,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  value,
    input  logic              load,
    input  logic [DIGITS-1:0] dp_mask,
    input  logic              blank_lz,
    output logic              busy,
    output logic              overflow,
    output logic [DIGITS-1:0] an,
    output logic [7:0]        seg
);

    localparam int BW   = 4 * DIGITS;
    localparam int CW   = $clog2(WIDTH + 1);
    localparam int DIVW = $clog2(REFRESH_DIV);
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    // Segment order a..g, active-low.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b0000001;
            4'd1:    glyph = 7'b1001111;
            4'd2:    glyph = 7'b0010010;
            4'd3:    glyph = 7'b0000110;
            4'd4:    glyph = 7'b1001100;
            4'd5:    glyph = 7'b0100100;
            4'd6:    glyph = 7'b0100000;
            4'd7:    glyph = 7'b0001111;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0000100;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  binReg_q;
    logic [BW-1:0]     bcdReg_q;
    logic [CW-1:0]     cnt_q;
    logic              ovfPend_q;
    logic              busy_q;
    logic [BW-1:0]     dispBcd_q;
    logic              dispOvf_q;
    logic [DIVW-1:0]   div_q;
    logic [IDXW-1:0]   idx_q;
    logic [DIGITS-1:0] an_q, an_d;
    logic [7:0]        seg_q, seg_d;

    logic [BW-1:0]     bcdAdj;
    logic [BW-1:0]     bcdReg_d;
    logic [WIDTH-1:0]  binReg_d;

    always_comb begin
        bcdAdj = bcdReg_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcdReg_q[4*k +: 4] >= 4'd5)
                bcdAdj[4*k +: 4] = bcdReg_q[4*k +: 4] + 4'd3;
        end
        {bcdReg_d, binReg_d} = {bcdAdj, binReg_q} << 1;
    end

    // Display registers change only in COMMIT, so the scan never sees a half-converted value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            binReg_q  <= '0;
            bcdReg_q  <= '0;
            cnt_q     <= '0;
            ovfPend_q <= 1'b0;
            busy_q    <= 1'b0;
            dispBcd_q <= '0;
            dispOvf_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        binReg_q  <= value;
                        bcdReg_q  <= '0;
                        ovfPend_q <= ({{(64-WIDTH){1'b0}}, value} >= LIMIT);
                        cnt_q     <= CW'(WIDTH);
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcdReg_q <= bcdReg_d;
                    binReg_q <= binReg_d;
                    cnt_q    <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        state_q <= COMMIT;
                end
                COMMIT: begin
                    dispBcd_q <= bcdReg_q;
                    dispOvf_q <= ovfPend_q;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIVW'(REFRESH_DIV - 1)) begin
            div_q <= '0;
            idx_q <= (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + IDXW'(1);
        end else begin
            div_q <= div_q + DIVW'(1);
        end
    end

    // Leading-zero test covers the scanned digit and everything to its left.
    always_comb begin
        logic       upperZero;
        logic [6:0] g;
        upperZero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= int'(idx_q) && dispBcd_q[4*k +: 4] != 4'd0)
                upperZero = 1'b0;
        end
        if (dispOvf_q)
            g = 7'b1111110;
        else if (blank_lz && idx_q != '0 && upperZero)
            g = 7'b1111111;
        else
            g = glyph(dispBcd_q[4*idx_q +: 4]);
        seg_d = {g, ~dp_mask[idx_q]};
        an_d  = ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= 8'hFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign busy     = busy_q;
    assign overflow = dispOvf_q;
    assign an       = an_q;
    assign seg      = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with a short refresh period so every digit
// can be observed within a few cycles.
module tb_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic [13:0] value;
    logic        load;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic        busy;
    logic        overflow;
    logic [3:0]  an;
    logic [7:0]  seg;

    int testsRun  = 0;
    int failCount = 0;
    int cycles;

    seg_scan_driver #(
        .DIGITS(4),
        .WIDTH(14),
        .REFRESH_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .value(value),
        .load(load),
        .dp_mask(dp_mask),
        .blank_lz(blank_lz),
        .busy(busy),
        .overflow(overflow),
        .an(an),
        .seg(seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [13:0] v);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic checkDigit(input int d, input logic [7:0] exp);
        logic [3:0] anExp;
        int n;
        anExp = ~(4'b0001 << d);
        n = 0;
        @(negedge clk);
        while (an !== anExp && n < 40) begin
            n++;
            @(negedge clk);
        end
        checkOutput($sformatf("an_d%0d", d), {28'd0, an}, {28'd0, anExp});
        checkOutput($sformatf("seg_d%0d", d), {24'd0, seg}, {24'd0, exp});
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value    = '0;
        dp_mask  = 4'b0000;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_an",   {28'd0, an},  32'hF);
        checkOutput("rst_seg",  {24'd0, seg}, 32'hFF);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_ovf",  {31'd0, overflow}, 32'd0);

        rst = 1'b0;
        @(negedge clk);
        checkOutput("first_an",  {28'd0, an},  32'hE);
        checkOutput("first_seg", {24'd0, seg}, 32'h03);
        for (int n = 0; n < 16; n++) begin
            logic [3:0] anExp;
            anExp = ~(4'b0001 << ((n / 4) % 4));
            checkOutput($sformatf("scan_%0d", n), {28'd0, an}, {28'd0, anExp});
            @(negedge clk);
        end

        // 1234 -> glyphs 1,2,3,4
        applyStimulus(14'd1234);
        waitIdle(cycles);
        checkOutput("busy_len_1234", cycles, 15);
        checkOutput("ovf_1234", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        checkDigit(3, 8'h9F);
        checkDigit(2, 8'h25);
        checkDigit(1, 8'h0D);
        checkDigit(0, 8'h99);

        // leading-zero blanking on a single-digit value
        blank_lz = 1'b1;
        applyStimulus(14'd7);
        waitIdle(cycles);
        checkOutput("busy_len_7", cycles, 15);
        repeat (2) @(negedge clk);
        checkDigit(3, 8'hFF);
        checkDigit(2, 8'hFF);
        checkDigit(1, 8'hFF);
        checkDigit(0, 8'h1F);
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        checkDigit(3, 8'h03);
        checkDigit(2, 8'h03);
        checkDigit(1, 8'h03);

        // overflow shows dashes, dp still honoured
        applyStimulus(14'd12000);
        waitIdle(cycles);
        checkOutput("ovf_12000", {31'd0, overflow}, 32'd1);
        repeat (2) @(negedge clk);
        checkDigit(3, 8'hFD);
        checkDigit(2, 8'hFD);
        checkDigit(1, 8'hFD);
        checkDigit(0, 8'hFD);
        dp_mask = 4'b0100;
        repeat (2) @(negedge clk);
        checkDigit(2, 8'hFC);
        checkDigit(0, 8'hFD);
        dp_mask = 4'b0000;

        // load during busy is ignored
        applyStimulus(14'd9999);
        value = 14'd5;
        load  = 1'b1;
        repeat (9) @(negedge clk);
        load  = 1'b0;
        waitIdle(cycles);
        checkOutput("ovf_9999", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        checkDigit(3, 8'h09);
        checkDigit(2, 8'h09);
        checkDigit(1, 8'h09);
        checkDigit(0, 8'h09);
        applyStimulus(14'd5);
        waitIdle(cycles);
        checkOutput("busy_len_5", cycles, 15);
        repeat (2) @(negedge clk);
        checkDigit(3, 8'h03);
        checkDigit(2, 8'h03);
        checkDigit(1, 8'h03);
        checkDigit(0, 8'h49);

        // reset in the middle of a conversion
        applyStimulus(14'd1234);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_an",   {28'd0, an},  32'hF);
        checkOutput("midrst_seg",  {24'd0, seg}, 32'hFF);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_ovf",  {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("postrst_busy", {31'd0, busy}, 32'd0);
        checkDigit(3, 8'h03);
        checkDigit(2, 8'h03);
        checkDigit(1, 8'h03);
        checkDigit(0, 8'h03);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
